mult_div_unit: RTL and testbench

//   Multi-cycle MIPS multiply/divide engine for MULT, MULTU, DIV and DIVU.

---
 rtl/mult_div_unit.sv | 179 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide engine (MULT, MULTU, DIV, DIVU).
// Drives the write strobes and write data of the HI/LO register pair.
// A multiply produces its result MUL_LAT cycles after accept.
// A divide uses a 32-step restoring divider and finishes 33 cycles after accept.
module mult_div_unit #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        hi_write,
  output logic        lo_write,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Count loaded on accept so that MUL_RUN lasts MUL_LAT-1 cycles.
  localparam int MUL_CNT = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] quo_q, quo_d;    // dividend bits shift out at the top, quotient bits in at the bottom
  logic [31:0] rem_q, rem_d;    // partial remainder (magnitude)
  logic [31:0] dvs_q, dvs_d;    // divisor magnitude
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        is_signed;
  logic [63:0] ext_a, ext_b, mul_now;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] diff, step_rem, step_quo, fin_quo, fin_rem;

  assign accept    = in_valid && (state_q == IDLE) && !flush;
  assign is_signed = !op[0];

  // Operand preparation: extension for the 64-bit product, magnitudes for the divider.
  assign ext_a   = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
  assign ext_b   = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
  assign mul_now = ext_a * ext_b;
  assign a_mag   = (is_signed && a[31]) ? (~a + 32'd1) : a;
  assign b_mag   = (is_signed && b[31]) ? (~b + 32'd1) : b;

  // One restoring-division step: bring down the next dividend bit, subtract if it fits.
  assign shifted  = {rem_q, quo_q[31]};
  assign ge       = shifted >= {1'b0, dvs_q};
  assign diff     = shifted[31:0] - dvs_q;
  assign step_rem = ge ? diff : shifted[31:0];
  assign step_quo = {quo_q[30:0], ge};

  // Sign fix-up after the last step; a zero divisor forces an all-ones quotient.
  assign fin_quo = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? (~step_quo + 32'd1) : step_quo);
  assign fin_rem = r_neg_q ? (~step_rem + 32'd1) : step_rem;

  // Next-state and datapath update.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (flush && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (op[1]) begin
              state_d = DIV_RUN;
              cnt_d   = 5'd31;
              quo_d   = a_mag;
              rem_d   = 32'd0;
              dvs_d   = b_mag;
              q_neg_d = is_signed && (a[31] ^ b[31]);
              r_neg_d = is_signed && a[31];
              dz_d    = (b == 32'd0);
            end else if (MUL_LAT == 1) begin
              state_d = DONE;
              hi_d    = mul_now[63:32];
              lo_d    = mul_now[31:0];
            end else begin
              state_d = MUL_RUN;
              cnt_d   = 5'(MUL_CNT);
              prod_d  = mul_now;
            end
          end
        end
        MUL_RUN: begin
          if (cnt_q == 5'd0) begin
            state_d = DONE;
            hi_d    = prod_q[63:32];
            lo_d    = prod_q[31:0];
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        DIV_RUN: begin
          quo_d = step_quo;
          rem_d = step_rem;
          if (cnt_q == 5'd0) begin
            state_d = DONE;
            hi_d    = fin_rem;
            lo_d    = fin_quo;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // A flush that arrives in DONE suppresses the strobe in that same cycle.
  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign hi_write = (state_q == DONE) && !flush;
  assign lo_write = (state_q == DONE) && !flush;
  assign hi_data  = hi_q;
  assign lo_data  = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed corner cases plus randomized traffic.
// The driver pushes expected results into a queue; the monitor pops one per strobe.
module tb_mult_div_unit;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy;
  logic        hi_write, lo_write;
  logic [31:0] hi_data, lo_data;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          done;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  mult_div_unit #(.MUL_LAT(MUL_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .busy     (busy),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .hi_data  (hi_data),
    .lo_data  (lo_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: returns {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned p;
    case (o)
      2'd0: begin
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        return 64'(sx * sy);
      end
      2'd1: begin
        p = {32'b0, x} * {32'b0, y};
        return p;
      end
      2'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Called at a negedge; holds the request until accepted and leaves in_valid high.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit expect_result, output int t);
    logic [63:0] r;
    bit          done = 0;
    exp_t        e;
    t        = -1;
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    for (int k = 0; k < 200 && !done; k++) begin
      if (in_ready) begin
        t = cyc;
        if (expect_result) begin
          r      = model(o, x, y);
          e.hi   = r[63:32];
          e.lo   = r[31:0];
          e.done = t + (o[1] ? DIV_LAT : MUL_LAT);
          exp_q.push_back(e);
        end
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (hi_write || lo_write)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {62'd0, hi_write, lo_write}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("hi_write", 64'(hi_write), 64'd1);
        check("lo_write", 64'(lo_write), 64'd1);
        check("hi_data", 64'(hi_data), 64'(e.hi));
        check("lo_data", 64'(lo_data), 64'(e.lo));
        check("done_cycle", 64'(cyc), 64'(e.done));
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
  end

  initial begin
    int t, t2;
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    op       = 2'd0;
    a        = 32'd0;
    b        = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi_write", 64'(hi_write), 64'd0);
    check("reset_hi_data", 64'(hi_data), 64'd0);
    check("reset_lo_data", 64'(lo_data), 64'd0);

    // Multiply signed vs unsigned, back to back.
    issue(2'd0, 32'hFFFF_FFFF, 32'd2, 1, t);
    issue(2'd1, 32'hFFFF_FFFF, 32'd2, 1, t2);
    check("mul_period", 64'(t2 - t), 64'(MUL_LAT + 1));
    in_valid = 1'b0;
    drain();

    // Divide sign handling, divide by zero, overflow case.
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1, t);
    issue(2'd3, 32'd7, 32'd2, 1, t2);
    check("div_period", 64'(t2 - t), 64'(DIV_LAT + 1));
    issue(2'd3, 32'h0000_1234, 32'd0, 1, t);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, t);
    issue(2'd2, 32'hFFFF_FFF9, 32'd0, 1, t);
    in_valid = 1'b0;
    drain();

    // Flush together with a request in IDLE blocks the accept.
    in_valid = 1'b1;
    op       = 2'd1;
    flush    = 1'b1;
    @(negedge clk);
    check("flush_blocks_accept", 64'(busy), 64'd0);
    in_valid = 1'b0;
    flush    = 1'b0;

    // Flush in the middle of a divide, then a multiply.
    issue(2'd2, 32'd1000, 32'd7, 0, t);
    in_valid = 1'b0;
    while (cyc < t + 10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_div_in_ready", 64'(in_ready), 64'd1);
    check("flush_div_cycle", 64'(cyc), 64'(t + 11));
    issue(2'd1, 32'd3, 32'd5, 1, t);
    in_valid = 1'b0;
    drain();

    // Flush arriving in DONE suppresses the strobe.
    issue(2'd1, 32'd6, 32'd7, 0, t);
    in_valid = 1'b0;
    while (cyc < t + MUL_LAT - 1) @(negedge clk);
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_done_no_strobe", 64'(hi_write), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_done_in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of a divide discards it and clears the data.
    issue(2'd2, 32'd12345, 32'd11, 0, t);
    in_valid = 1'b0;
    while (cyc < t + 20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_hi_data", 64'(hi_data), 64'd0);
    check("midreset_lo_data", 64'(lo_data), 64'd0);
    reset   = 1'b0;
    last_hi = 32'd0;
    last_lo = 32'd0;
    repeat (40) @(negedge clk);

    // in_valid held high through a divide: next op accepted exactly 34 cycles later.
    issue(2'd3, 32'd100, 32'd9, 1, t);
    issue(2'd0, 32'hFFFF_FFFD, 32'd4, 1, t2);
    check("held_valid_accept", 64'(t2 - t), 64'(DIV_LAT + 1));
    in_valid = 1'b0;
    drain();

    // Randomized traffic with occasional idle gaps.
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = pick();
      ry = pick();
      issue(ro, rx, ry, 1, t);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    drain();
    check("hold_hi_data", 64'(hi_data), 64'(last_hi));
    check("hold_lo_data", 64'(lo_data), 64'(last_lo));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
